// File: rtl/multiword_csa_adder_pkg.sv
// Shared definitions for the multi-word carry-select adder:
// slice width, FSM state encoding and the counter-width helper.
package multiword_csa_adder_pkg;

    // Width of one datapath slice (the carry-select adder width).
    localparam int SLICE_W = 32;

    // Sub-block width inside the 32-bit carry-select adder.
    localparam int CSA_BLK_W = 4;

    // Sequencer states: IDLE waits for start, RUN walks the slices.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Ceiling log2 with a floor of one bit, so that a single-slice
    // configuration still gets a legal (1-bit) counter.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < n) begin
                r = r + 1;
            end
        end
        if (r < 1) begin
            r = 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/multiword_csa_adder_csa32.sv
// CarrySelectAdder32: 32-bit carry-select adder built from 4-bit blocks.
// Block 0 adds with the real carry-in; every other block precomputes
// its sum for carry-in 0 and 1 and the incoming block carry picks one.
module CarrySelectAdder32
    import multiword_csa_adder_pkg::*;
(
    input  logic [SLICE_W-1:0] A,
    input  logic [SLICE_W-1:0] B,
    input  logic               Cin,
    output logic [SLICE_W-1:0] Sum,
    output logic               Cout
);

    localparam int NBLK = SLICE_W / CSA_BLK_W;

    // Block carry chain; c[0] is the adder carry-in.
    logic [NBLK:0] c;

    assign c[0] = Cin;

    for (genvar g = 0; g < NBLK; g++) begin : g_blk
        logic [CSA_BLK_W:0] r0;
        logic [CSA_BLK_W:0] r1;

        // Both speculative results; the top bit is the block carry-out.
        assign r0 = {1'b0, A[g*CSA_BLK_W +: CSA_BLK_W]}
                  + {1'b0, B[g*CSA_BLK_W +: CSA_BLK_W]};
        assign r1 = {1'b0, A[g*CSA_BLK_W +: CSA_BLK_W]}
                  + {1'b0, B[g*CSA_BLK_W +: CSA_BLK_W]}
                  + (CSA_BLK_W+1)'(1);

        // The carry arriving from the lower block selects the result.
        assign Sum[g*CSA_BLK_W +: CSA_BLK_W] = c[g] ? r1[CSA_BLK_W-1:0]
                                                     : r0[CSA_BLK_W-1:0];
        assign c[g+1] = c[g] ? r1[CSA_BLK_W] : r0[CSA_BLK_W];
    end

    assign Cout = c[NBLK];

endmodule

// File: rtl/multiword_csa_adder.sv
// multiword_csa_adder: sequential WORDS*32-bit adder that streams one
// 32-bit slice per clock (LSB slice first) through a single
// CarrySelectAdder32, with the inter-slice carry held in a register.
//
// Optional build macro: MWADD_OVF_EN adds the signed-overflow output Ovf.
//
// Handshake: start is only looked at while busy is low. A start seen
// at a rising edge with busy low is accepted: A, B and Cin are captured
// on that edge and busy rises. WORDS edges later done pulses high for
// one cycle while busy drops; Sum/Cout (and Ovf) are valid from then
// until the next accepted operation begins writing slices. A start
// presented during the done cycle is accepted on the following edge.
module multiword_csa_adder
    import multiword_csa_adder_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [WORDS*SLICE_W-1:0]   A,
    input  logic [WORDS*SLICE_W-1:0]   B,
    input  logic                       Cin,
    output logic                       busy,
    output logic                       done,
    output logic [WORDS*SLICE_W-1:0]   Sum,
`ifdef MWADD_OVF_EN
    output logic                       Cout,
    output logic                       Ovf
`else
    output logic                       Cout
`endif
);

    localparam int W  = WORDS * SLICE_W;
    localparam int CW = clog2(WORDS);
    localparam logic [CW-1:0] LAST_IDX = CW'(WORDS - 1);

    state_t              state;
    state_t              state_nxt;
    logic [CW-1:0]       cnt;
    logic                carry;
    logic [W-1:0]        a_reg;
    logic [W-1:0]        b_reg;
    logic [W-1:0]        sum_reg;
    logic                cout_reg;
    logic                done_reg;

    logic                accept;
    logic                running;
    logic                last_slice;
    logic [SLICE_W-1:0]  a_sl;
    logic [SLICE_W-1:0]  b_sl;
    logic [SLICE_W-1:0]  add_sum;
    logic                add_cout;

`ifdef MWADD_OVF_EN
    logic                ovf_reg;
`endif

    assign accept     = (state == IDLE) && start;
    assign running    = (state == RUN);
    assign last_slice = (cnt == LAST_IDX);

    // Select the operand slice addressed by the slice counter.
    always_comb begin
        a_sl = '0;
        b_sl = '0;
        for (int k = 0; k < WORDS; k++) begin
            if (cnt == CW'(k)) begin
                a_sl = a_reg[k*SLICE_W +: SLICE_W];
                b_sl = b_reg[k*SLICE_W +: SLICE_W];
            end
        end
    end

    // The one shared slice datapath.
    CarrySelectAdder32 u_csa (
        .A    (a_sl),
        .B    (b_sl),
        .Cin  (carry),
        .Sum  (add_sum),
        .Cout (add_cout)
    );

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next state: leave IDLE on start, return after the last slice.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt = RUN;
                end
            end
            RUN: begin
                if (last_slice) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand capture, slice sequencing, result and carry registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            carry    <= 1'b0;
            a_reg    <= '0;
            b_reg    <= '0;
            sum_reg  <= '0;
            cout_reg <= 1'b0;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (accept) begin
                a_reg <= A;
                b_reg <= B;
                carry <= Cin;
                cnt   <= '0;
            end else if (running) begin
                for (int k = 0; k < WORDS; k++) begin
                    if (cnt == CW'(k)) begin
                        sum_reg[k*SLICE_W +: SLICE_W] <= add_sum;
                    end
                end
                carry <= add_cout;
                if (last_slice) begin
                    cnt      <= '0;
                    cout_reg <= add_cout;
                    done_reg <= 1'b1;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end
        end
    end

`ifdef MWADD_OVF_EN
    // Signed overflow is judged on the final slice, using the sign bit
    // the adder is producing on that very edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_reg <= 1'b0;
        end else if (running && last_slice) begin
            ovf_reg <= (a_reg[W-1] == b_reg[W-1]) &&
                       (add_sum[SLICE_W-1] != a_reg[W-1]);
        end
    end

    assign Ovf = ovf_reg;
`endif

    assign busy = running;
    assign done = done_reg;
    assign Sum  = sum_reg;
    assign Cout = cout_reg;

endmodule

// File: doc/multiword_csa_adder.md
Name: multiword_csa_adder

Overview:
- Sequential multi-word adder that wraps the 32-bit carry-select adder.
- Latches two WORDS*32-bit operands on a start pulse and feeds them one 32-bit slice per clock through a single CarrySelectAdder32 instance, LSB slice first.
- Carry is registered between slices. The full sum and carry-out are presented with a one-cycle done pulse.
- Sits directly upstream of the adder and drives its A, B and Cin inputs; consumes its Sum and Cout outputs.

Parameters:
- WORDS, 4, number of 32-bit slices; operand width W = WORDS*32; legal range 1..64.

Ports:
- clk  input  1  system clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a new addition; sampled only in IDLE.
- A  input  W  operand A; sampled on the accepted start edge.
- B  input  W  operand B; sampled on the accepted start edge.
- Cin  input  1  carry into slice 0; sampled on the accepted start edge.
- busy  output  1  high while an operation is in progress.
- done  output  1  one-cycle pulse: Sum and Cout valid.
- Sum  output  W  registered result.
- Cout  output  1  carry out of the MSB slice.
- Ovf  output  1  signed overflow; present only with MWADD_OVF_EN.

Behaviour:
- Clocking and reset:
  - Single clock, clk. Reset rst is synchronous and active-high.
  - Reset values: state=IDLE, busy=0, done=0, Sum=0, Cout=0, Ovf=0, slice counter=0, carry register=0, operand registers=0.
- FSM has two states, IDLE and RUN.
  - IDLE, start=1 at edge E0: latch A, B, Cin into the operand and carry registers; counter=0; go to RUN; busy=1 from E0.
  - RUN, each edge: slice k=counter.
    - Drive the adder with A_reg[32k+31:32k], B_reg[32k+31:32k] and the carry register.
    - Write the adder's Sum into Sum[32k+31:32k]; load the adder's Cout into the carry register; counter++.
  - RUN, edge on which k=WORDS-1: Cout=adder Cout; done=1 for exactly one cycle; busy=0; go to IDLE.
- Latency: done is asserted on edge E0+WORDS, i.e. WORDS cycles after the accepted start. Throughput is one operation per WORDS+1 cycles at best.
- Any start while busy=1 is ignored. Operand registers are not reloaded.
- start high in the cycle where done=1: state is IDLE, so it is accepted. Back-to-back operations with no bubble beyond the IDLE edge.
- Sum validity:
  - Sum slices update progressively during RUN and are only defined as valid while done=1 or in IDLE after done.
  - Sum and Cout hold their values until the next accepted start's first slice write.
- Counter width is clog2(WORDS), minimum 1 bit. WORDS=1: done one cycle after start.
- Arithmetic is unsigned modulo 2^W, with Cout as bit W. Cin is added into slice 0 only.
- rst in any state, including mid-RUN: all state returns to reset values on that edge. No done pulse is produced for the aborted operation. rst has priority over start.

Optional Feature:
- Macro MWADD_OVF_EN.
- Defined:
  - Ovf port exists. Ovf is registered on the final-slice edge, together with done.
  - Ovf = (A_reg[W-1] == B_reg[W-1]) && (Sum[W-1] != A_reg[W-1]).
  - Ovf holds its value until the next accepted start and is cleared by rst.
- Not defined: Ovf port and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package/include:
  - SLICE_W=32.
  - FSM state encoding: IDLE=1'b0, RUN=1'b1.
  - Counter-width function clog2.
- Sub-module: the existing CarrySelectAdder32, instantiated once as the slice datapath. No other sub-modules.

Test Plan:
All cases use WORDS=4 (W=128).
1. A=all ones, B=1, Cin=0 -> Sum=0, Cout=1, done exactly 4 cycles after the start edge, busy high for those 4 cycles.
2. A=0x00000000_00000000_00000000_FFFFFFFF, B=1, Cin=0 -> Sum=0x00000000_00000000_00000001_00000000, Cout=0. Checks inter-slice carry.
3. A=0xAAAAAAAA repeated, B=0x55555555 repeated, Cin=1 -> Sum=0, Cout=1. Checks carry ripple through all slices.
4. start with A=1, B=2; re-assert start with A=B=all ones two cycles later -> second start ignored; Sum=3, Cout=0. Then a start in the done cycle is accepted.
5. rst asserted on the edge of slice 2 of a running op -> next cycle busy=0, Sum=0, Cout=0, no done pulse. A new start (A=5, B=7) then completes with Sum=12.
6. With MWADD_OVF_EN defined:
   - A=0x7FFF...FFFF, B=1 -> Ovf=1, Cout=0.
   - A=0xFFFF...FFFF, B=1 -> Ovf=0, Cout=1.
   - Without the macro, compile and confirm the Ovf port is absent.
